spi_xfer_ctrl: RTL

//  Sequences multi-byte SPI transactions on top of the spi_transmit_byte engine.

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_xfer_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI transaction sequencer
package spi_pkg;

   localparam int SPI_LEN_W = 8;
   localparam int SPI_DLY_W = 4;

   // Sent on MOSI during read transactions; TX stream is not consumed
   localparam logic [7:0] SPI_DUMMY_BYTE = 8'hFF;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      LOAD  = 3'd2,
      XFER  = 3'd3,
      HOLD  = 3'd4,
      GAP   = 3'd5
   } xfer_state_e;

endpackage

// File: rtl/spi_xfer_ctrl.sv
// rtl/spi_xfer_ctrl.sv - multi-byte SPI transaction sequencer with chip-select timing
module spi_xfer_ctrl
   import spi_pkg::*;
#(
   parameter int LEN_W = SPI_LEN_W,
   parameter int DLY_W = SPI_DLY_W
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [LEN_W-1:0] len_i,
   input  logic             read_i,
   input  logic [DLY_W-1:0] cs_setup_i,
   input  logic [DLY_W-1:0] cs_hold_i,
   input  logic [DLY_W-1:0] cs_gap_i,
   input  logic [7:0]       tx_data_i,
   input  logic             tx_valid_i,
   output logic             tx_ready_o,
   output logic [7:0]       rx_data_o,
   output logic             rx_valid_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             aborted_o,
   output logic             ss_n_o,
   output logic             byte_start_o,
   output logic [7:0]       byte_data_o,
   output logic             byte_read_o,
   input  logic             byte_ready_i,
   input  logic             byte_valid_i,
   input  logic [7:0]       byte_data_i
);

   xfer_state_e      r_state;
   logic [LEN_W-1:0] r_len_cnt;
   logic [DLY_W-1:0] r_dly_cnt;
   logic [DLY_W-1:0] r_hold;
   logic [DLY_W-1:0] r_gap;
   logic             r_read;
   logic             r_abort;
   logic [7:0]       r_rx_data;
   logic             r_rx_valid;
   logic             r_busy;
   logic             r_done;
   logic             r_aborted;
   logic             r_ss_n;
   logic             r_byte_start;
   logic [7:0]       r_byte_data;

   logic             w_dly_last;
   logic             w_launch;
   logic             w_last_byte;

   // A delay of 0 or 1 both spend exactly one cycle in the timed state
   assign w_dly_last  = (r_dly_cnt == '0) || (r_dly_cnt == DLY_W'(1));
   assign w_last_byte = (r_len_cnt == '0);

   // Abort wins over a launch so no TX byte is consumed that would never be sent
   assign w_launch   = (r_state == LOAD) && !abort_i && byte_ready_i && (r_read || tx_valid_i);
   assign tx_ready_o = (r_state == LOAD) && !abort_i && !r_read && byte_ready_i;

   assign rx_data_o    = r_rx_data;
   assign rx_valid_o   = r_rx_valid;
   assign busy_o       = r_busy;
   assign done_o       = r_done;
   assign aborted_o    = r_aborted;
   assign ss_n_o       = r_ss_n;
   assign byte_start_o = r_byte_start;
   assign byte_data_o  = r_byte_data;
   assign byte_read_o  = r_read;

   // Transaction FSM: chip-select timing, byte launch/collect and registered outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state      <= IDLE;
         r_len_cnt    <= '0;
         r_dly_cnt    <= '0;
         r_hold       <= '0;
         r_gap        <= '0;
         r_read       <= 1'b0;
         r_abort      <= 1'b0;
         r_rx_data    <= '0;
         r_rx_valid   <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_aborted    <= 1'b0;
         r_ss_n       <= 1'b1;
         r_byte_start <= 1'b0;
         r_byte_data  <= '0;
      end else begin
         r_byte_start <= 1'b0;
         r_rx_valid   <= 1'b0;
         r_done       <= 1'b0;
         r_aborted    <= 1'b0;

         case (r_state)
            IDLE: begin
               r_abort <= 1'b0;
               // The done cycle itself still reads as IDLE; a new start waits one more cycle
               if (start_i && !r_done) begin
                  r_len_cnt <= len_i;
                  r_read    <= read_i;
                  r_dly_cnt <= cs_setup_i;
                  r_hold    <= cs_hold_i;
                  r_gap     <= cs_gap_i;
                  r_busy    <= 1'b1;
                  r_ss_n    <= 1'b0;
                  r_state   <= SETUP;
               end
            end

            SETUP: begin
               if (abort_i) begin
                  r_abort   <= 1'b1;
                  r_dly_cnt <= r_hold;
                  r_state   <= HOLD;
               end else if (w_dly_last) begin
                  r_state <= LOAD;
               end else begin
                  r_dly_cnt <= r_dly_cnt - DLY_W'(1);
               end
            end

            LOAD: begin
               if (abort_i) begin
                  r_abort   <= 1'b1;
                  r_dly_cnt <= r_hold;
                  r_state   <= HOLD;
               end else if (w_launch) begin
                  r_byte_data  <= r_read ? SPI_DUMMY_BYTE : tx_data_i;
                  r_byte_start <= 1'b1;
                  r_state      <= XFER;
               end
            end

            XFER: begin
               // The engine cannot be cut mid-byte, so abort here is only remembered
               if (abort_i) begin
                  r_abort <= 1'b1;
               end
               if (byte_valid_i) begin
                  r_rx_data  <= byte_data_i;
                  r_rx_valid <= 1'b1;
                  if (w_last_byte || r_abort || abort_i) begin
                     r_dly_cnt <= r_hold;
                     r_state   <= HOLD;
                  end else begin
                     r_len_cnt <= r_len_cnt - LEN_W'(1);
                     r_state   <= LOAD;
                  end
               end
            end

            HOLD: begin
               if (w_dly_last) begin
                  r_ss_n    <= 1'b1;
                  r_dly_cnt <= r_gap;
                  r_state   <= GAP;
               end else begin
                  r_dly_cnt <= r_dly_cnt - DLY_W'(1);
               end
            end

            GAP: begin
               if (w_dly_last) begin
                  r_done    <= 1'b1;
                  r_aborted <= r_abort;
                  r_busy    <= 1'b0;
                  r_state   <= IDLE;
               end else begin
                  r_dly_cnt <= r_dly_cnt - DLY_W'(1);
               end
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule
